// File: rtl/alu_disp_pkg.sv
// alu_disp_pkg: shared FSM state type and active-low glyph constants for alu_seg_display.
// Segment order is {dp,g,f,e,d,c,b,a}; a 0 lights the segment.
package alu_disp_pkg;

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        LOCK  = 2'd1,
        SHOW  = 2'd2
    } state_e;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;  // g only
    localparam logic [7:0] SEG_C     = 8'hC6;  // carry
    localparam logic [7:0] SEG_O     = 8'hA3;  // overflow
    localparam logic [7:0] SEG_B     = 8'h83;  // carry and overflow

endpackage

// File: rtl/seg7_hex.sv
// seg7_hex: combinational 4-bit to active-low 7-segment hex encoder, dp always off.
module seg7_hex (
    input  logic [3:0] value_i,
    output logic [7:0] seg_o
);

    // Hex font lookup
    always_comb begin
        seg_o = 8'hFF;
        unique case (value_i)
            4'h0: seg_o = 8'hC0;
            4'h1: seg_o = 8'hF9;
            4'h2: seg_o = 8'hA4;
            4'h3: seg_o = 8'hB0;
            4'h4: seg_o = 8'h99;
            4'h5: seg_o = 8'h92;
            4'h6: seg_o = 8'h82;
            4'h7: seg_o = 8'hF8;
            4'h8: seg_o = 8'h80;
            4'h9: seg_o = 8'h90;
            4'hA: seg_o = 8'h88;
            4'hB: seg_o = 8'h83;
            4'hC: seg_o = 8'hC6;
            4'hD: seg_o = 8'hA1;
            4'hE: seg_o = 8'h86;
            4'hF: seg_o = 8'h8E;
        endcase
    end

endmodule

// File: rtl/alu_seg_display.sv
// alu_seg_display: captures {res, car, of, ctrl, signed_mode} on a valid/ready handshake and
// scans it onto a 4-digit active-low 7-segment display (d3 opcode, d2 flags, d1 sign, d0 value).
// Optional overflow blink of digits 0/1 is built when ALU_SEG_BLINK_EN is defined.
module alu_seg_display #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned HOLD_CYC = 16
`ifdef ALU_SEG_BLINK_EN
    ,
    parameter int unsigned BLINK_DIV = 2**20
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_res,
    input  logic       in_car,
    input  logic       in_of,
    input  logic [2:0] in_ctrl,
    input  logic       signed_mode,
    output logic [7:0] seg,
    output logic [3:0] an
);

    import alu_disp_pkg::*;

    localparam int unsigned DIV_W  = $clog2(SCAN_DIV);
    localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [1:0]          dig_idx_q, dig_idx_d;
    logic [3:0]          res_q, res_d;
    logic                car_q, car_d;
    logic                of_q, of_d;
    logic [2:0]          ctrl_q, ctrl_d;
    logic                sgn_q, sgn_d;
    logic [7:0]          seg_q, seg_d;
    logic [3:0]          an_q, an_d;

    logic                xfer;
    logic                blink_hide;
    logic [3:0]          mag;
    logic [3:0]          hex_val;
    logic [7:0]          hex_seg;
    logic [7:0]          glyph;

    assign in_ready = (state_q != LOCK);
    assign xfer     = in_valid && in_ready;

    // Handshake FSM: LOCK holds in_ready low for HOLD_CYC cycles after every capture
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            BLANK, SHOW: begin
                if (xfer) begin
                    state_d    = LOCK;
                    hold_cnt_d = HOLD_W'(HOLD_CYC - 1);
                end
            end
            LOCK: begin
                if (hold_cnt_q == '0) begin
                    state_d = SHOW;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            default: state_d = BLANK;
        endcase
    end

    // Snapshot registers load only on a transfer
    always_comb begin
        res_d  = res_q;
        car_d  = car_q;
        of_d   = of_q;
        ctrl_d = ctrl_q;
        sgn_d  = sgn_q;
        if (xfer) begin
            res_d  = in_res;
            car_d  = in_car;
            of_d   = in_of;
            ctrl_d = in_ctrl;
            sgn_d  = signed_mode;
        end
    end

    // Scan divider and digit index; runs in every state
    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        dig_idx_d = dig_idx_q;
        if (div_cnt_q == DIV_W'(SCAN_DIV - 1)) begin
            div_cnt_d = '0;
            dig_idx_d = dig_idx_q + 2'd1;
        end
    end

`ifdef ALU_SEG_BLINK_EN
    localparam int unsigned BLINK_W = $clog2(2 * BLINK_DIV);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;

    // Blink phase counter; restarts on capture so the visible phase comes first
    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        if (xfer || (blink_cnt_q == BLINK_W'(2 * BLINK_DIV - 1))) begin
            blink_cnt_d = '0;
        end
    end

    // Blink counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign blink_hide = of_q && (blink_cnt_q >= BLINK_W'(BLINK_DIV));
`else
    assign blink_hide = 1'b0;
`endif

    // Signed mode shows the magnitude; 4'b1000 negates to itself, which reads as 8
    assign mag     = (sgn_q && res_q[3]) ? (4'd0 - res_q) : res_q;
    assign hex_val = (dig_idx_q == 2'd3) ? {1'b0, ctrl_q} : mag;

    seg7_hex u_seg7_hex (
        .value_i(hex_val),
        .seg_o  (hex_seg)
    );

    // Glyph for the digit currently selected by the scan
    always_comb begin
        glyph = SEG_BLANK;
        unique case (dig_idx_q)
            2'd0: glyph = blink_hide ? SEG_BLANK : hex_seg;
            2'd1: glyph = (!blink_hide && sgn_q && res_q[3]) ? SEG_MINUS : SEG_BLANK;
            2'd2: begin
                if (car_q && of_q) begin
                    glyph = SEG_B;
                end else if (car_q) begin
                    glyph = SEG_C;
                end else if (of_q) begin
                    glyph = SEG_O;
                end
            end
            2'd3: glyph = hex_seg;
        endcase
    end

    // Next values of the registered pin drivers
    always_comb begin
        seg_d = glyph;
        an_d  = ~(4'b0001 << dig_idx_q);
        if (state_q == BLANK) begin
            seg_d = SEG_BLANK;
            an_d  = 4'hF;
        end
    end

    // State, counters, snapshot and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BLANK;
            hold_cnt_q <= '0;
            div_cnt_q  <= '0;
            dig_idx_q  <= '0;
            res_q      <= '0;
            car_q      <= 1'b0;
            of_q       <= 1'b0;
            ctrl_q     <= '0;
            sgn_q      <= 1'b0;
            seg_q      <= SEG_BLANK;
            an_q       <= 4'hF;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            div_cnt_q  <= div_cnt_d;
            dig_idx_q  <= dig_idx_d;
            res_q      <= res_d;
            car_q      <= car_d;
            of_q       <= of_d;
            ctrl_q     <= ctrl_d;
            sgn_q      <= sgn_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule
